// File: rtl/xyz_stim_gen.sv
// xyz_stim_gen: sweeps {x,y,z} through all 8 patterns, checks a_in against x|y|z, counts mismatches
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   start, abort     run request (idle/done only) and run cancel (wins over start)
//   a_in             OR result returned by the leaf under test
//   x, y, z, idx     registered stimulus bits and the index of the pattern driven
//   busy, done       run in progress / last run completed
//   err_cnt          saturating mismatch count of the current or last run
// Macro XYZ_STIM_GRAY_EN selects Gray pattern order instead of binary.
module xyz_stim_gen #(
    parameter int HOLD_CYCLES = 4,
    parameter int PASSES      = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             a_in,
    output logic             x,
    output logic             y,
    output logic             z,
    output logic [2:0]       idx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam int PW = PASSES > 1 ? $clog2(PASSES) : 1;
    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
    state_t state, state_nx;
    logic [HW-1:0] hold;
    logic [PW-1:0] pass;
    logic last_hold, wrap, last_pass, go;
    function automatic logic [2:0] pattern(input logic [2:0] i);
`ifdef XYZ_STIM_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction
    assign last_hold = hold == HW'(HOLD_CYCLES - 1);
    assign wrap      = last_hold && idx == 3'd7;
    assign last_pass = pass == PW'(PASSES - 1);
    assign go        = start && !abort && state != DRIVE;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            {x, y, z} <= 3'b000;
            idx     <= 3'd0;
            hold    <= '0;
            pass    <= '0;
            err_cnt <= '0;
        end else begin
            state <= state_nx;
            if (abort) begin
                {x, y, z} <= 3'b000;
                idx  <= 3'd0;
                hold <= '0;
                pass <= '0;
            end else if (go) begin
                {x, y, z} <= pattern(3'd0);
                idx     <= 3'd0;
                hold    <= '0;
                pass    <= '0;
                err_cnt <= '0;
            end else if (state == DRIVE) begin
                hold <= last_hold ? '0 : hold + 1'b1;
                if (last_hold) idx <= idx + 3'd1;
                if (wrap) pass <= pass + 1'b1;
                if (last_hold && a_in != (x | y | z) && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                {x, y, z} <= (wrap && last_pass) ? 3'b000 : last_hold ? pattern(idx + 3'd1) : {x, y, z};
            end
        end
    end
    always_comb begin
        state_nx = abort ? IDLE : go ? DRIVE : (state == DRIVE && wrap && last_pass) ? DONE : state;
    end
    always_comb begin
        busy = state == DRIVE;
        done = state == DONE;
    end
endmodule

// File: tb/tb_xyz_stim_gen.sv
// tb_xyz_stim_gen: scoreboard bench for xyz_stim_gen with nominal, short-hold and saturation instances
module tb_xyz_stim_gen;
    typedef struct { int dut; int err; int len; } exp_t;
    localparam logic [2:0] GRAY [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    localparam int HOLD_P [3] = '{4, 1, 4};
    logic clk = 0, rst_n = 0;
    logic start_v [3], abort_v [3], a_v [3], fault_v [3];
    logic x_v [3], y_v [3], z_v [3], busy_v [3], done_v [3], done_q [3];
    logic [2:0] idx_v [3];
    logic [7:0] err_v [3];
    int k [3];
    int n_chk = 0, n_pass = 0;
    exp_t q [$];
    exp_t e;
    always #5 clk = ~clk;
    xyz_stim_gen #(.HOLD_CYCLES(4), .PASSES(1), .CNT_W(8)) d0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]), .a_in(a_v[0]),
        .x(x_v[0]), .y(y_v[0]), .z(z_v[0]), .idx(idx_v[0]), .busy(busy_v[0]), .done(done_v[0]), .err_cnt(err_v[0]));
    xyz_stim_gen #(.HOLD_CYCLES(1), .PASSES(1), .CNT_W(8)) d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]), .a_in(a_v[1]),
        .x(x_v[1]), .y(y_v[1]), .z(z_v[1]), .idx(idx_v[1]), .busy(busy_v[1]), .done(done_v[1]), .err_cnt(err_v[1]));
    xyz_stim_gen #(.HOLD_CYCLES(4), .PASSES(40), .CNT_W(8)) d2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]), .a_in(a_v[2]),
        .x(x_v[2]), .y(y_v[2]), .z(z_v[2]), .idx(idx_v[2]), .busy(busy_v[2]), .done(done_v[2]), .err_cnt(err_v[2]));
    always_comb for (int i = 0; i < 3; i++) a_v[i] = fault_v[i] ? 1'b0 : (x_v[i] | y_v[i] | z_v[i]);
    function automatic logic [2:0] pat(input int i);
        logic [2:0] b;
        b = 3'(i);
`ifdef XYZ_STIM_GRAY_EN
        return GRAY[b];
`else
        return b;
`endif
    endfunction
    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (busy_v[i]) begin
                check("pattern", {x_v[i], y_v[i], z_v[i]}, pat((k[i] / HOLD_P[i]) % 8));
                check("idx", idx_v[i], (k[i] / HOLD_P[i]) % 8);
                k[i]++;
            end else begin
                if (done_v[i] && !done_q[i]) begin
                    if (q.size() == 0) check("unexpected_done", i, -1);
                    else begin
                        e = q.pop_front();
                        check("done_dut", i, e.dut);
                        check("err_cnt", err_v[i], e.err);
                        check("run_len", k[i], e.len);
                        check("done_xyz", {x_v[i], y_v[i], z_v[i]}, 0);
                    end
                end
                k[i] = 0;
            end
            done_q[i] = done_v[i];
        end
    end
    task automatic pulse_start(input int i);
        @(posedge clk); #1 start_v[i] = 1;
        @(posedge clk); #1 start_v[i] = 0;
    endtask
    task automatic wait_done(input int i, input int budget);
        int n;
        n = 0;
        while (!done_v[i] && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done_v[i]) check("done_timeout", 0, 1);
        @(negedge clk); #1;
    endtask
    initial begin
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 0; abort_v[i] = 0; fault_v[i] = 0; k[i] = 0; done_q[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1 check("rst_state", {x_v[0], y_v[0], z_v[0], idx_v[0], busy_v[0], done_v[0], err_v[0]}, 0);
        rst_n = 1;
        q.push_back('{0, 0, 32});
        pulse_start(0);
        wait_done(0, 100);
        fault_v[0] = 1;
        q.push_back('{0, 7, 32});
        pulse_start(0);
        wait_done(0, 100);
        fault_v[0] = 0;
        q.push_back('{0, 0, 32});
        pulse_start(0);
        repeat (4) @(posedge clk);
        #1 start_v[0] = 1;
        @(posedge clk); #1 start_v[0] = 0;
        wait_done(0, 100);
        fault_v[0] = 1;
        pulse_start(0);
        repeat (12) @(posedge clk);
        #1 abort_v[0] = 1;
        @(posedge clk); #1 abort_v[0] = 0;
        check("abort_busy", busy_v[0], 0);
        check("abort_done", done_v[0], 0);
        check("abort_xyz", {x_v[0], y_v[0], z_v[0]}, 0);
        check("abort_idx", idx_v[0], 0);
        check("abort_err", err_v[0], 2);
        @(posedge clk); #1 abort_v[0] = 1; start_v[0] = 1;
        @(posedge clk); #1 abort_v[0] = 0; start_v[0] = 0;
        @(posedge clk); #1;
        check("abort_start_busy", busy_v[0], 0);
        check("abort_start_err", err_v[0], 2);
        fault_v[0] = 0;
        pulse_start(0);
        repeat (11) @(posedge clk);
        #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        check("midrun_rst", {x_v[0], y_v[0], z_v[0], idx_v[0], busy_v[0], done_v[0], err_v[0]}, 0);
        q.push_back('{0, 0, 32});
        pulse_start(0);
        wait_done(0, 100);
        q.push_back('{1, 0, 8});
        pulse_start(1);
        wait_done(1, 50);
        fault_v[2] = 1;
        q.push_back('{2, 255, 1280});
        pulse_start(2);
        wait_done(2, 1500);
        repeat (2) @(posedge clk);
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
